// File: rtl/fifo_stream_client_pkg.sv
// Shared types and default widths for the FIFO stream initiator/checker.
package fifo_stream_client_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_stream_client_seq_gen.sv
// Arithmetic sequence register: loads a base value, then advances by stride on each step.
module fifo_stream_client_seq_gen #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] base_i,
  input  logic         step_i,
  input  logic [W-1:0] stride_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q, value_d;

  // Next value: load wins over step; the add wraps modulo 2^W.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = base_i;
    end else if (step_i) begin
      value_d = value_q + stride_i;
    end else begin
      value_d = value_q;
    end
  end

  // Value register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/fifo_stream_client.sv
// Traffic initiator and checker for a single-entry FIFO: enqueues an arithmetic
// sequence, dequeues and verifies every word, and accumulates their sum.
module fifo_stream_client
  import fifo_stream_client_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start__ENA,
  input  logic [DATA_W-1:0] start_base,
  input  logic [DATA_W-1:0] start_stride,
  input  logic [CNT_W-1:0]  start_count,
  output logic              start__RDY,
  output logic              fifo_enq__ENA,
  output logic [DATA_W-1:0] fifo_enq_v,
  input  logic              fifo_enq__RDY,
  output logic              fifo_deq__ENA,
  input  logic              fifo_deq__RDY,
  input  logic [DATA_W-1:0] fifo_first,
  input  logic              fifo_first__RDY,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              error
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   stride_q, stride_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0]    cons_q, cons_d;
  logic                error_q, error_d;
  logic                start_acc_s;
  logic                enq_ena_s;
  logic                deq_ena_s;
  logic [DATA_W-1:0]   next_v_s;
  logic [DATA_W-1:0]   exp_v_s;

  assign start__RDY  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_acc_s = start__ENA && start__RDY;

  // ENAs depend only on registered state and the matching RDY inputs.
  assign enq_ena_s = (state_q == ST_RUN) && (prod_q < total_q) && fifo_enq__RDY;
  assign deq_ena_s = (state_q == ST_RUN) && (cons_q < total_q) &&
                     fifo_deq__RDY && fifo_first__RDY;

  fifo_stream_client_seq_gen #(.W(DATA_W)) u_prod_seq (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .load_i   (start_acc_s),
    .base_i   (start_base),
    .step_i   (enq_ena_s),
    .stride_i (stride_q),
    .value_o  (next_v_s)
  );

  fifo_stream_client_seq_gen #(.W(DATA_W)) u_exp_seq (
    .clk_i    (CLK),
    .rst_ni   (nRST),
    .load_i   (start_acc_s),
    .base_i   (start_base),
    .step_i   (deq_ena_s),
    .stride_i (stride_q),
    .value_o  (exp_v_s)
  );

  // FSM next state, counters, running sum and sticky mismatch flag.
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    sum_d    = sum_q;
    total_d  = total_q;
    prod_d   = prod_q;
    cons_d   = cons_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          stride_d = start_stride;
          total_d  = start_count;
          prod_d   = '0;
          cons_d   = '0;
          sum_d    = '0;
          error_d  = 1'b0;
          if (start_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (enq_ena_s) begin
          prod_d = prod_q + CNT_ONE;
        end else begin
          prod_d = prod_q;
        end
        if (deq_ena_s) begin
          sum_d  = sum_q + fifo_first;
          cons_d = cons_q + CNT_ONE;
          // A wrong word is still consumed; only the flag records it.
          if (fifo_first != exp_v_s) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          if ((cons_q + CNT_ONE) == total_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      stride_q <= '0;
      sum_q    <= '0;
      total_q  <= '0;
      prod_q   <= '0;
      cons_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      sum_q    <= sum_d;
      total_q  <= total_d;
      prod_q   <= prod_d;
      cons_q   <= cons_d;
      error_q  <= error_d;
    end
  end

  assign fifo_enq__ENA = enq_ena_s;
  assign fifo_enq_v    = next_v_s;
  assign fifo_deq__ENA = deq_ena_s;
  assign done          = (state_q == ST_DONE);
  assign sum           = sum_q;
  assign error         = error_q;

endmodule

// File: tb/tb_fifo_stream_client.sv
// Directed bench: a Fifo1 model between enq and deq, table of runs, plus
// hand-written backpressure and reset-mid-run sequences.
module tb_fifo_stream_client;

  logic        CLK;
  logic        nRST;
  logic        start__ENA;
  logic [31:0] start_base;
  logic [31:0] start_stride;
  logic [15:0] start_count;
  logic        start__RDY;
  logic        fifo_enq__ENA;
  logic [31:0] fifo_enq_v;
  logic        fifo_enq__RDY;
  logic        fifo_deq__ENA;
  logic        fifo_deq__RDY;
  logic [31:0] fifo_first;
  logic        fifo_first__RDY;
  logic        done;
  logic [31:0] sum;
  logic        error;

  int tests_run;
  int tests_failed;

  logic        full_q;
  logic [31:0] data_q;
  logic        deq_hold;
  int          corrupt_idx;
  logic        clr;
  int          enq_cnt;
  int          deq_cnt;
  int          proto_err;
  logic [31:0] enq_log [0:15];

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] count;
    int          corrupt;
    logic [31:0] exp_sum;
    logic        exp_err;
    int          max_cyc;
  } vec_t;

  vec_t vecs [6];

  fifo_stream_client dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .start__ENA      (start__ENA),
    .start_base      (start_base),
    .start_stride    (start_stride),
    .start_count     (start_count),
    .start__RDY      (start__RDY),
    .fifo_enq__ENA   (fifo_enq__ENA),
    .fifo_enq_v      (fifo_enq_v),
    .fifo_enq__RDY   (fifo_enq__RDY),
    .fifo_deq__ENA   (fifo_deq__ENA),
    .fifo_deq__RDY   (fifo_deq__RDY),
    .fifo_first      (fifo_first),
    .fifo_first__RDY (fifo_first__RDY),
    .done            (done),
    .sum             (sum),
    .error           (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Fifo1 model: one slot, so enq and deq never coincide.
  assign fifo_enq__RDY   = !full_q;
  assign fifo_deq__RDY   = full_q && !deq_hold;
  assign fifo_first__RDY = full_q;
  assign fifo_first      = data_q;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full_q <= 1'b0;
      data_q <= 32'd0;
    end else if (fifo_enq__ENA) begin
      full_q <= 1'b1;
      data_q <= (enq_cnt == corrupt_idx) ? fifo_enq_v + 32'd1 : fifo_enq_v;
    end else if (fifo_deq__ENA) begin
      full_q <= 1'b0;
    end
  end

  // Traffic monitor: counts transfers, logs enq data, flags ENA without RDY.
  always @(posedge CLK) begin
    if (clr) begin
      enq_cnt <= 0;
      deq_cnt <= 0;
    end else begin
      if (fifo_enq__ENA) begin
        if (enq_cnt < 16) enq_log[enq_cnt] <= fifo_enq_v;
        enq_cnt <= enq_cnt + 1;
      end
      if (fifo_deq__ENA) deq_cnt <= deq_cnt + 1;
    end
    if (fifo_enq__ENA && !fifo_enq__RDY) proto_err <= proto_err + 1;
    if (fifo_deq__ENA && !(fifo_deq__RDY && fifo_first__RDY)) proto_err <= proto_err + 1;
    if ((enq_cnt - deq_cnt) > 1) proto_err <= proto_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
    start__ENA   = 1'b1;
    start_base   = b;
    start_stride = s;
    start_count  = c;
    clr          = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start__ENA = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (done) break;
      @(negedge CLK);
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_results(input vec_t v);
    int bad;
    bad = 0;
    check("sum", sum, v.exp_sum);
    check("error", {31'd0, error}, {31'd0, v.exp_err});
    check("enq_count", enq_cnt, {16'd0, v.count});
    check("deq_count", deq_cnt, {16'd0, v.count});
    for (int i = 0; i < int'(v.count) && i < 16; i++) begin
      if (enq_log[i] !== v.base + 32'(i) * v.stride) bad++;
    end
    check("enq_seq", bad, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    corrupt_idx = v.corrupt;
    do_start(v.base, v.stride, v.count);
    check("done_after_accept", {31'd0, done}, {31'd0, (v.count == 16'd0)});
    check("rdy_after_accept", {31'd0, start__RDY}, {31'd0, (v.count == 16'd0)});
    wait_done(v.max_cyc);
    check_results(v);
  endtask

  initial begin
    vec_t rv;
    tests_run    = 0;
    tests_failed = 0;
    proto_err    = 0;
    enq_cnt      = 0;
    deq_cnt      = 0;
    clr          = 1'b0;
    deq_hold     = 1'b0;
    corrupt_idx  = -1;
    nRST         = 1'b0;
    start__ENA   = 1'b0;
    start_base   = 32'd0;
    start_stride = 32'd0;
    start_count  = 16'd0;

    vecs[0] = '{base: 32'd5, stride: 32'd3, count: 16'd4, corrupt: -1,
                exp_sum: 32'd38, exp_err: 1'b0, max_cyc: 10};
    vecs[1] = '{base: 32'd7, stride: 32'd2, count: 16'd0, corrupt: -1,
                exp_sum: 32'd0, exp_err: 1'b0, max_cyc: 1};
    vecs[2] = '{base: 32'hFFFF_FFFE, stride: 32'd1, count: 16'd3, corrupt: -1,
                exp_sum: 32'hFFFF_FFFD, exp_err: 1'b0, max_cyc: 10};
    vecs[3] = '{base: 32'd5, stride: 32'd3, count: 16'd4, corrupt: 1,
                exp_sum: 32'd39, exp_err: 1'b1, max_cyc: 10};
    vecs[4] = '{base: 32'd5, stride: 32'd3, count: 16'd4, corrupt: -1,
                exp_sum: 32'd38, exp_err: 1'b0, max_cyc: 10};
    vecs[5] = '{base: 32'd100, stride: 32'hFFFF_FFFF, count: 16'd5, corrupt: -1,
                exp_sum: 32'd490, exp_err: 1'b0, max_cyc: 12};

    repeat (2) @(negedge CLK);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_start_rdy", {31'd0, start__RDY}, 32'd1);
    check("rst_enq_ena", {31'd0, fifo_enq__ENA}, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
      repeat (2) @(negedge CLK);
    end

    // Backpressure: stall the dequeue side for 20 cycles mid-run.
    corrupt_idx = -1;
    do_start(32'd10, 32'd10, 16'd4);
    for (int i = 0; i < 20 && deq_cnt < 1; i++) @(negedge CLK);
    check("bp_first_deq", deq_cnt, 32'd1);
    deq_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        start__ENA   = 1'b1;
        start_base   = 32'd999;
        start_stride = 32'd7;
        start_count  = 16'd1;
        check("bp_start_rdy_low", {31'd0, start__RDY}, 32'd0);
      end else begin
        start__ENA = 1'b0;
      end
      @(negedge CLK);
    end
    start__ENA = 1'b0;
    check("bp_enq_held", enq_cnt, 32'd2);
    check("bp_deq_held", deq_cnt, 32'd1);
    deq_hold = 1'b0;
    wait_done(12);
    rv = '{base: 32'd10, stride: 32'd10, count: 16'd4, corrupt: -1,
           exp_sum: 32'd100, exp_err: 1'b0, max_cyc: 12};
    check_results(rv);
    repeat (2) @(negedge CLK);

    // Reset during word 2 of a run whose first word was corrupted.
    corrupt_idx = 0;
    do_start(32'd5, 32'd3, 16'd4);
    for (int i = 0; i < 20 && !(enq_cnt == 2 && deq_cnt == 1); i++) @(negedge CLK);
    check("mid_enq_cnt", enq_cnt, 32'd2);
    check("mid_error_set", {31'd0, error}, 32'd1);
    check("mid_sum", sum, 32'd6);
    nRST = 1'b0;
    #1;
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_error", {31'd0, error}, 32'd0);
    check("rstmid_sum", sum, 32'd0);
    check("rstmid_enq_ena", {31'd0, fifo_enq__ENA}, 32'd0);
    check("rstmid_deq_ena", {31'd0, fifo_deq__ENA}, 32'd0);
    repeat (2) @(negedge CLK);
    check("rsthold_sum", sum, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_start_rdy", {31'd0, start__RDY}, 32'd1);
    rv = '{base: 32'd1, stride: 32'd1, count: 16'd2, corrupt: -1,
           exp_sum: 32'd3, exp_err: 1'b0, max_cyc: 8};
    run_vec(rv);

    check("protocol", proto_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_stream_client.md
Name: fifo_stream_client

Overview:
- Drives the enq side and drains the deq side of a single-entry FIFO (Fifo1-style in$enq / out$deq / out$first interface).
- On a start command it generates an arithmetic sequence of 32-bit words and enqueues them.
- Concurrently it dequeues every word, checks it against an independently generated expected sequence, and accumulates a sum.
- Used as the traffic initiator/checker in the rule-based FIFO examples and their self-test top.

Parameters:
- DATA_W, 32, width of enq/first data and of the running sum.
- CNT_W, 16, width of the word count and of the produced/consumed counters.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- start__ENA  input  1  start command; acted on only when start__RDY=1
- start$base  input  DATA_W  first value of the sequence
- start$stride  input  DATA_W  increment between values
- start$count  input  CNT_W  number of words to produce and consume
- start__RDY  output  1  high in IDLE or DONE
- fifo$enq__ENA  output  1  enqueue strobe
- fifo$enq$v  output  DATA_W  enqueue data
- fifo$enq__RDY  input  1  FIFO can accept
- fifo$deq__ENA  output  1  dequeue strobe
- fifo$deq__RDY  input  1  FIFO can dequeue
- fifo$first  input  DATA_W  head data
- fifo$first__RDY  input  1  head data valid
- done  output  1  high in DONE
- sum  output  DATA_W  running sum of dequeued words, modulo 2^DATA_W
- error  output  1  sticky; set on first mismatch

Behaviour:
- State: IDLE, RUN, DONE. Reset (async, nRST=0) forces IDLE, all counters/registers 0, sum=0, error=0, done=0.
- Reset timing: all outputs return to reset values immediately and stay there while nRST=0. This applies mid-RUN too, with no partial completion.
- Start accept: start__ENA & start__RDY.
  - Latches base and stride.
  - Loads next_v=base, exp_v=base, prod_cnt=0, cons_cnt=0, total=count.
  - Clears sum and error.
  - Next state is RUN, or DONE if count==0 (done rises the cycle after accept; no FIFO activity).
- start__ENA while start__RDY=0 is ignored.
- Enqueue (RUN only): fifo$enq__ENA = (state==RUN) & (prod_cnt<total) & fifo$enq__RDY, combinational.
  - fifo$enq$v = next_v.
  - On enq: next_v += stride (wraps mod 2^DATA_W), prod_cnt += 1.
- Dequeue (RUN only): fifo$deq__ENA = (state==RUN) & (cons_cnt<total) & fifo$deq__RDY & fifo$first__RDY.
  - On deq: sum += fifo$first, exp_v += stride, cons_cnt += 1.
  - If fifo$first != exp_v, error <= 1 (sticky until next start or reset). The word is still consumed and summed.
- ENA is never asserted without the matching RDY. ENA does not depend combinationally on its own RDY's consumer (no loop beyond RDY->ENA).
- Simultaneous enq and deq in one cycle are allowed and both take effect.
- RUN -> DONE on the cycle a deq makes cons_cnt==total. done is asserted from the following cycle.
- In DONE: sum and error hold; start__RDY=1. A new start restarts the sequence from the new base.
- Excess FIFO data (first__RDY while cons_cnt==total) is never dequeued.
- Counters never exceed total. count up to 2^CNT_W-1 is legal.
- Latency through a 1-entry FIFO: the word enqueued in cycle t is dequeued no earlier than t+1. With Fifo1 the steady-state rate is one word per 2 cycles; the block must not assume a faster rate.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) and default DATA_W/CNT_W constants.
- One natural sub-module, seq_gen: holds a value register, loads base, and advances by stride on a step strobe.
  - Instantiate it twice: producer value next_v and checker value exp_v.
- The rest (FSM, counters, sum, error) stays in fifo_stream_client.

Test Plan:
- Basic run against Fifo1_OC_35: base=5, stride=3, count=4 -> enq values 5,8,11,14; deq same order; sum=38, error=0, done=1. Completion within 10 cycles of start.
- Zero count: count=0 -> no enq/deq ENA ever; done=1 one cycle after start; sum=0.
- Wrap: base=32'hFFFF_FFFE, stride=1, count=3 -> values FFFFFFFE, FFFFFFFF, 0; sum=32'hFFFF_FFFD; error=0.
- Mismatch: bench FIFO model corrupts 2nd word (8 -> 9) for base=5, stride=3, count=4 -> error=1 sticky, sum=39, done=1. A following clean start clears error.
- Backpressure: hold fifo$deq__RDY=0 for 20 cycles mid-run -> no deq ENA, at most one enq outstanding, no lost or duplicated words; final sum correct.
- Reset mid-run: drop nRST during word 2 of count=4 -> done, error, sum and ENAs go 0 immediately. After release, start__RDY=1 and a new run (base=1, stride=1, count=2) yields sum=3.
